// File: rtl/ram_bist_march_ctrl.sv
// March C- BIST controller for a single-port synchronous RAM with a one-cycle read latency.
// Runs the six March C- elements, records the first failing address and then holds in DONE.
module ram_bist_march_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        M4   = 3'd5,
        M5   = 3'd6,
        DONE = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state;
    logic              phase_b;
    logic [ADDR_W-1:0] addr;

    function automatic logic descending(input state_t s);
        return (s == M3) || (s == M4);
    endfunction

    function automatic logic [DATA_W-1:0] read_bg(input state_t s);
        return ((s == M2) || (s == M4)) ? '1 : '0;
    endfunction

    function automatic logic [DATA_W-1:0] write_bg(input state_t s);
        return ((s == M1) || (s == M3)) ? '1 : '0;
    endfunction

    logic              elem_end;
    logic [ADDR_W-1:0] addr_step;
    state_t            next_elem;
    logic [ADDR_W-1:0] next_first;
    logic              mismatch;

    assign elem_end   = descending(state) ? (addr == '0) : (addr == ADDR_LAST);
    assign addr_step  = descending(state) ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
    assign next_elem  = state_t'(state + 3'd1);
    assign next_first = descending(next_elem) ? ADDR_LAST : '0;
    assign mismatch   = (ram_rdata != read_bg(state));

    // The address counter doubles as the RAM address, so it holds whenever no strobe is active.
    assign ram_addr = addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            phase_b   <= 1'b0;
            addr      <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= M0;
                        phase_b   <= 1'b0;
                        addr      <= '0;
                        ram_we    <= 1'b1;
                        ram_re    <= 1'b0;
                        ram_wdata <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                    end
                end
                M0: begin
                    if (elem_end) begin
                        state  <= M1;
                        addr   <= '0;
                        ram_we <= 1'b0;
                        ram_re <= 1'b1;
                    end else begin
                        addr <= addr_step;
                    end
                end
                default: begin
                    if (!phase_b) begin
                        phase_b <= 1'b1;
                        ram_re  <= 1'b0;
                        if (state != M5) begin
                            ram_we    <= 1'b1;
                            ram_wdata <= write_bg(state);
                        end
                    end else begin
                        // Read data requested in phase A is on ram_rdata now.
                        phase_b <= 1'b0;
                        ram_we  <= 1'b0;
                        if (mismatch && !fail) begin
                            fail      <= 1'b1;
                            fail_addr <= addr;
                        end
                        if (elem_end) begin
                            if (state == M5) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state  <= next_elem;
                                addr   <= next_first;
                                ram_re <= 1'b1;
                            end
                        end else begin
                            addr   <= addr_step;
                            ram_re <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ram_bist_march_ctrl.md
# ram_bist_march_ctrl

March C- BIST controller for a single-port synchronous RAM. On `start` it runs the six March C- elements over every address and compares each read against the expected background. It flags the first failing address and reports completion. Its 3-bit control state is the state register of the RAM BIST datapath: it drives RAM address, write data and strobes, and it consumes RAM read data.

## Interface
- `ADDR_W`, 4, RAM address width; N = 2^ADDR_W words
- `DATA_W`, 8, RAM word width
- `clk`  input  1  clock; all state changes on rising edge
- `reset`  input  1  asynchronous, active-low reset (0 = reset)
- `start`  input  1  begin a test run; sampled only in IDLE or DONE
- `ram_rdata`  input  DATA_W  RAM read data, valid the cycle after `ram_re`
- `ram_addr`  output  ADDR_W  RAM address
- `ram_wdata`  output  DATA_W  RAM write data; all-0 or all-1
- `ram_we`  output  1  RAM write strobe
- `ram_re`  output  1  RAM read strobe
- `busy`  output  1  high while a March element is running
- `done`  output  1  high in DONE
- `fail`  output  1  sticky; set by any compare mismatch during the run
- `fail_addr`  output  ADDR_W  address of the first mismatch in the run

## Operation
- The state register is 3 bits and holds 8 states: IDLE=0, M0..M5=1..6, DONE=7. A 1-bit phase flag (A/B) and an ADDR_W-bit address counter complete the control state.
- March elements, using D0 = all zeros and D1 = all ones:
  - M0 ⇑ w0
  - M1 ⇑ (r0, w1)
  - M2 ⇑ (r1, w0)
  - M3 ⇓ (r0, w1)
  - M4 ⇓ (r1, w0)
  - M5 ⇑ r0
- Address order: ⇑ runs 0 to N-1; ⇓ runs N-1 to 0.
- M0 uses 1 cycle per address: `ram_we`=1, `ram_wdata`=D0.
- M1–M4 use 2 cycles per address, on the same address:
  - Phase A: `ram_re`=1.
  - Phase B: compare `ram_rdata` with the expected value, and `ram_we`=1 with the new background.
- M5 uses 2 cycles per address:
  - Phase A: `ram_re`=1.
  - Phase B: compare only; no strobes.
- `ram_re` and `ram_we` are never high in the same cycle.
- Element transitions:
  - After the last address of an element, the next cycle starts the following element at its first address, with no idle cycle between elements.
  - After M5's last compare, the next state is DONE.
- Compare failure: on a mismatch with `fail`=0, set `fail`=1 and latch `fail_addr` = current address. Later mismatches leave `fail_addr` unchanged. The run always continues to DONE.
- IDLE/DONE with `start`=1:
  - Next state is M0 at address 0.
  - Clear `fail` and `fail_addr`.
  - `done` drops.
- `start` is ignored while `busy`=1.
- DONE holds `done`=1 until the next `start` or reset.
- When no strobe is active, `ram_wdata` and `ram_addr` hold their last values.

## Timing
- Reset (`reset`=0), effective immediately and asynchronously:
  - state=IDLE, phase=A, address=0.
  - All outputs 0: `ram_addr`, `ram_wdata`, `ram_we`, `ram_re`, `busy`, `done`, `fail`, `fail_addr`.
- Reset mid-run aborts the test with no completion pulse. The first rising edge after release sees IDLE.
- All outputs are registered or decoded purely from registers; no combinational path from `ram_rdata` or `start` to any output.
- `start`=1 at edge k (in IDLE) gives `busy`=1 and the M0 write to address 0 during cycle k+1.
- Run length is N + 4·2N + 2N = 11N cycles; 176 for N=16.
- `done`=1 from cycle k+1+11N; `busy` falls in the same cycle.
- Read latency of 1 is fixed: data requested in phase A is compared in phase B.
- `fail`/`fail_addr` update at the edge ending the phase-B compare cycle.

## Test plan
- Fault-free RAM model, N=16, `start` pulse at edge k:
  - `done` rises at cycle k+177 with `fail`=0.
  - Exactly 16+64=80 write strobes and 80 read strobes.
- RAM with bit 3 of address 5 stuck-at-1:
  - `fail`=1 and `fail_addr`=5 after the M1 compare of address 5.
  - Both still hold at DONE despite the later M3/M5 mismatches.
- Address sequence check:
  - M3's first phase-A `ram_addr`=15 and its last is 0.
  - M4 follows directly, starting at 15.
- `start` held high for the entire run:
  - No restart during `busy`.
  - In DONE the run restarts on the next edge with `fail` cleared.
- `reset` driven low mid-M2 (address 7, phase B), asynchronous to `clk`:
  - All outputs 0 immediately.
  - A subsequent `start` completes a fault-free run in 176 cycles.
- Stuck-at-0 at address 0, all bits: `fail_addr`=0, first detected in M2.
